// File: rtl/pong_pkg.sv
// Shared pong definitions: ball FSM state encoding and default screen/paddle geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMove   = 2'd1,
    StScored = 2'd2
  } pong_state_e;

  localparam int PONG_SCREEN_W    = 640;
  localparam int PONG_SCREEN_H    = 480;
  localparam int PONG_BALL_W      = 8;
  localparam int PONG_SPEED       = 2;
  localparam int PONG_PAD_W       = 8;
  localparam int PONG_PAD_H       = 64;
  localparam int PONG_PAD_L_X     = 16;
  localparam int PONG_PAD_R_X     = 616;
  localparam int PONG_HOLD_FRAMES = 60;

  // Top-left coordinate that centres a box of size box within extent.
  function automatic int pong_centre(input int extent, input int box);
    return (extent - box) / 2;
  endfunction

endpackage

// File: rtl/pong_axis_step.sv
// One axis of ball motion: advance by SPEED, then resolve an optional paddle barrier
// and the screen limits into the next position, direction and a limit-reached event.
module pong_axis_step #(
  parameter int BALL_W = 8,
  parameter int SPEED  = 2
) (
  input  logic signed [11:0] i_pos,
  input  logic               i_neg,
  input  logic               i_lo_bar_en,
  input  logic signed [11:0] i_lo_bar,
  input  logic               i_hi_bar_en,
  input  logic signed [11:0] i_hi_bar,
  input  logic signed [11:0] i_hi_lim,
  output logic signed [11:0] o_pos,
  output logic               o_neg,
  output logic               o_edge
);

  localparam logic signed [11:0] W    = 12'(BALL_W);
  localparam logic signed [11:0] S    = 12'(SPEED);
  localparam logic signed [11:0] ONE  = 12'sd1;
  localparam logic signed [11:0] ZERO = 12'sd0;

  logic signed [11:0] w_raw;

  always_comb begin
    w_raw  = i_neg ? (i_pos - S) : (i_pos + S);
    o_pos  = w_raw;
    o_neg  = i_neg;
    o_edge = 1'b0;
    if (!i_neg) begin
      // Barrier only counts when the box crosses its face during this step.
      if (i_hi_bar_en && ((i_pos + W) < i_hi_bar) && ((w_raw + W) >= i_hi_bar)) begin
        o_pos = i_hi_bar - W - ONE;
        o_neg = 1'b1;
      end else if ((w_raw + W) >= i_hi_lim) begin
        o_pos  = i_hi_lim - W;
        o_neg  = 1'b1;
        o_edge = 1'b1;
      end
    end else begin
      if (i_lo_bar_en && (i_pos > i_lo_bar) && (w_raw <= i_lo_bar)) begin
        o_pos = i_lo_bar + ONE;
        o_neg = 1'b0;
      end else if (w_raw <= ZERO) begin
        o_pos  = ZERO;
        o_neg  = 1'b0;
        o_edge = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: serve from centre, per-frame motion with wall/paddle bounces,
// score pulses on a miss and a frame-counted hold before returning to idle.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = PONG_SCREEN_W,
  parameter int SCREEN_H    = PONG_SCREEN_H,
  parameter int BALL_W      = PONG_BALL_W,
  parameter int SPEED       = PONG_SPEED,
  parameter int PAD_W       = PONG_PAD_W,
  parameter int PAD_H       = PONG_PAD_H,
  parameter int PAD_L_X     = PONG_PAD_L_X,
  parameter int PAD_R_X     = PONG_PAD_R_X,
  parameter int HOLD_FRAMES = PONG_HOLD_FRAMES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_serve,
  input  logic       i_pause,
  input  logic [8:0] i_paddle_l_y,
  input  logic [8:0] i_paddle_r_y,
  output logic [9:0] o_ball_x,
  output logic [8:0] o_ball_y,
  output logic [5:0] o_ball_width,
  output logic       o_score_l,
  output logic       o_score_r,
  output logic [1:0] o_state
);

  localparam logic [9:0] X_CTR = 10'(pong_centre(SCREEN_W, BALL_W));
  localparam logic [8:0] Y_CTR = 9'(pong_centre(SCREEN_H, BALL_W));
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic signed [11:0] W  = 12'(BALL_W);
  localparam logic signed [11:0] S  = 12'(SPEED);
  localparam logic signed [11:0] PH = 12'(PAD_H);

  pong_state_e       r_state;
  logic [9:0]        r_ball_x;
  logic [8:0]        r_ball_y;
  logic              r_vx_neg, r_vy_neg, r_conc_left;
  logic [HOLD_W-1:0] r_hold;
  logic              r_score_l, r_score_r;

  logic signed [11:0] w_x_cur, w_y_cur, w_ny, w_pl, w_pr, w_nx, w_nyc;
  logic               w_ovl_l, w_ovl_r, w_nvx_neg, w_nvy_neg, w_x_edge, w_update, w_hold_tick;
  logic               w_unused_y_edge, w_unused_bits;

  assign w_x_cur = signed'({2'b00, r_ball_x});
  assign w_y_cur = signed'({3'b000, r_ball_y});
  assign w_pl    = signed'({3'b000, i_paddle_l_y});
  assign w_pr    = signed'({3'b000, i_paddle_r_y});
  // Paddle overlap uses the raw next row, before any wall clamp.
  assign w_ny    = r_vy_neg ? (w_y_cur - S) : (w_y_cur + S);
  assign w_ovl_l = ((w_ny + W) >= w_pl) && (w_ny <= (w_pl + PH));
  assign w_ovl_r = ((w_ny + W) >= w_pr) && (w_ny <= (w_pr + PH));

  assign w_update    = (r_state == StMove) && i_frame_tick && !i_pause;
  assign w_hold_tick = (r_state == StScored) && i_frame_tick && !i_pause;

  pong_axis_step #(.BALL_W(BALL_W), .SPEED(SPEED)) u_x_step (
    .i_pos       (w_x_cur),
    .i_neg       (r_vx_neg),
    .i_lo_bar_en (w_ovl_l),
    .i_lo_bar    (12'(PAD_L_X + PAD_W)),
    .i_hi_bar_en (w_ovl_r),
    .i_hi_bar    (12'(PAD_R_X)),
    .i_hi_lim    (12'(SCREEN_W - 1)),
    .o_pos       (w_nx),
    .o_neg       (w_nvx_neg),
    .o_edge      (w_x_edge)
  );

  pong_axis_step #(.BALL_W(BALL_W), .SPEED(SPEED)) u_y_step (
    .i_pos       (w_y_cur),
    .i_neg       (r_vy_neg),
    .i_lo_bar_en (1'b0),
    .i_lo_bar    (12'sd0),
    .i_hi_bar_en (1'b0),
    .i_hi_bar    (12'sd0),
    .i_hi_lim    (12'(SCREEN_H - 1)),
    .o_pos       (w_nyc),
    .o_neg       (w_nvy_neg),
    .o_edge      (w_unused_y_edge)
  );

  assign w_unused_bits = ^{w_nx[11:10], w_nyc[11:9]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_ball_x    <= X_CTR;
      r_ball_y    <= Y_CTR;
      r_vx_neg    <= 1'b0;
      r_vy_neg    <= 1'b0;
      r_conc_left <= 1'b0;
      r_hold      <= '0;
      r_score_l   <= 1'b0;
      r_score_r   <= 1'b0;
    end else begin
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
      case (r_state)
        StIdle: begin
          r_ball_x <= X_CTR;
          r_ball_y <= Y_CTR;
          if (i_serve) begin
            r_state  <= StMove;
            r_vx_neg <= r_conc_left;
            r_vy_neg <= 1'b0;
          end
        end
        StMove: begin
          if (w_update) begin
            r_ball_x <= w_nx[9:0];
            r_ball_y <= w_nyc[8:0];
            r_vx_neg <= w_nvx_neg;
            r_vy_neg <= w_nvy_neg;
            if (w_x_edge) begin
              r_state     <= StScored;
              r_hold      <= '0;
              r_conc_left <= r_vx_neg;
              r_score_l   <= !r_vx_neg;
              r_score_r   <= r_vx_neg;
            end
          end
        end
        StScored: begin
          if (w_hold_tick) begin
            if (r_hold == HOLD_LAST) begin
              r_state  <= StIdle;
              r_hold   <= '0;
              r_ball_x <= X_CTR;
              r_ball_y <= Y_CTR;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
        end
        default: begin
          r_state  <= StIdle;
          r_ball_x <= X_CTR;
          r_ball_y <= Y_CTR;
          r_hold   <= '0;
        end
      endcase
    end
  end

  assign o_ball_x     = r_ball_x;
  assign o_ball_y     = r_ball_y;
  assign o_ball_width = 6'(BALL_W);
  assign o_score_l    = r_score_l;
  assign o_score_r    = r_score_r;
  assign o_state      = r_state;

endmodule

// File: doc/pong_ball_ctrl.md
PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_W, 8, ball box size (box spans x..x+BALL_W, y..y+BALL_W inclusive)
- SPEED, 2, pixels moved per axis per frame
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- PAD_L_X, 16, left paddle leftmost column
- PAD_R_X, 616, right paddle leftmost column
- HOLD_FRAMES, 60, frames held after a point
REQ-002 Ports SHALL be, one per line:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame end
- serve  in  1  level; starts play from IDLE
- pause  in  1  level; freezes motion and the hold counter
- paddle_l_y  in  9  left paddle top row
- paddle_r_y  in  9  right paddle top row
- ball_x  out  10  ball left column
- ball_y  out  9  ball top row
- ball_width  out  6  constant BALL_W
- score_l  out  1  one-cycle pulse: left player scores
- score_r  out  1  one-cycle pulse: right player scores
- state  out  2  IDLE=0, MOVE=1, SCORED=2
REQ-003 The clock and reset SHALL be one clock (clk) and an asynchronous, active-high reset (reset).

Function
REQ-004 The FSM SHALL have states IDLE, MOVE and SCORED; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-005 In IDLE, ball_x SHALL be (SCREEN_W-BALL_W)/2 (316) and ball_y SHALL be (SCREEN_H-BALL_W)/2 (236).
REQ-006 IDLE with serve=1 SHALL go to MOVE next cycle; vx SHALL be +SPEED toward the side that conceded the last point (right after reset); vy SHALL be +SPEED.
REQ-007 An "update" SHALL be a cycle with state=MOVE, frame_tick=1 and pause=0; ball outputs SHALL change exactly one cycle after the update cycle and hold otherwise.
REQ-008 Next-position arithmetic SHALL use signed 12-bit intermediates: nx=ball_x+vx, ny=ball_y+vy.
REQ-009 Top wall: ny<=0 SHALL give ball_y=0 and vy=+SPEED.
REQ-010 Bottom wall: ny+BALL_W>=SCREEN_H-1 SHALL give ball_y=SCREEN_H-1-BALL_W (471) and vy=-SPEED.
REQ-011 Right paddle hit (vx>0):
- Conditions: ball_x+BALL_W<PAD_R_X, nx+BALL_W>=PAD_R_X, ny+BALL_W>=paddle_r_y and ny<=paddle_r_y+PAD_H.
- Result: ball_x=PAD_R_X-BALL_W-1 (607), vx=-SPEED.
REQ-012 Left paddle hit SHALL mirror REQ-011:
- Conditions: ball_x>PAD_L_X+PAD_W, nx<=PAD_L_X+PAD_W, same y overlap against paddle_l_y.
- Result: ball_x=PAD_L_X+PAD_W+1 (25), vx=+SPEED.
REQ-013 Right miss (vx>0):
- Condition: nx+BALL_W>=SCREEN_W-1 with no hit.
- Result: score_l pulse one cycle after the update, ball_x=SCREEN_W-1-BALL_W, state=SCORED, conceded side=right.
REQ-014 Left miss (vx<0):
- Condition: nx<=0 with no hit.
- Result: score_r pulse, ball_x=0, state=SCORED, conceded side=left.
REQ-015 Paddle tests SHALL take priority over miss tests; the x outcome and the y wall outcome SHALL be applied in the same update.
REQ-016 SCORED SHALL freeze the ball and count HOLD_FRAMES frame_ticks (pause=0 only); it SHALL enter IDLE on the cycle after the final tick.
REQ-017 serve SHALL be ignored outside IDLE; frame_tick SHALL be ignored in IDLE.
REQ-018 score_l and score_r SHALL never both be high in the same cycle.

Reset
REQ-019 On reset assertion, asynchronously:
- state=IDLE, ball at (316,236)
- vx=+SPEED, vy=+SPEED, conceded side=right
- score_l=score_r=0, hold counter=0
REQ-020 A mid-game reset SHALL discard an in-flight update, and the first post-reset frame_tick SHALL not move the ball.

Structure
REQ-021 State encodings and default geometry constants SHALL live in a shared pong package used by this block and the VGA controller.
REQ-022 A sub-module pong_axis_step SHALL compute one axis (position, velocity, limits -> next position, velocity, event) and be instantiated twice.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset then 3 frame_ticks with serve=0 -> ball (316,236), state=0, no score pulses.
- serve=1 then one frame_tick -> one cycle later ball (318,238), state=1.
- Serve, paddle_r_y=400, 118 ticks -> y=471 and vy negative; at tick 146 -> x=607, vx negative, no score.
- Serve, paddle_r_y=0 -> score_l single pulse at wall; state=2; after 60 ticks -> IDLE at (316,236); next serve moves right.
- Assert pause during MOVE across 5 ticks -> no ball movement; release -> movement resumes on the next tick.
- Reset asserted during SCORED -> immediate IDLE at center, counter cleared, no pulse.
